// File: rtl/insr_fetch.sv
// Instruction fetch stage: requests one word at a time from instruction memory,
// holds it for the decoder, and follows branch/jump redirects.
module insr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] format,
   output logic        format_valid,
   input  logic        dec_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_out,
   output logic        misalign,
   output logic [31:0] instr_count
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            state_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   format_q;
   logic [XLEN-1:0]   pc_out_q;
   logic              format_valid_q;
   logic              imem_req_q;
   logic              misalign_q;
   logic [XLEN-1:0]   instr_count_q;

   logic [XLEN-1:0]   redirect_pc_d;
   logic [XLEN-1:0]   pc_next_d;

   // Redirect targets are forced to word alignment; the dropped bits raise misalign.
   assign redirect_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
   assign pc_next_d     = pc_q + PC_STEP;

   // Redirect pre-empts every state, so any same-cycle ack or handover is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_BOOT;
         pc_q           <= RESET_PC;
         format_q       <= NOP_WORD;
         pc_out_q       <= RESET_PC;
         format_valid_q <= 1'b0;
         imem_req_q     <= 1'b0;
         misalign_q     <= 1'b0;
         instr_count_q  <= '0;
      end else begin
         misalign_q <= 1'b0;
         if (redirect_valid) begin
            pc_q           <= redirect_pc_d;
            format_valid_q <= 1'b0;
            imem_req_q     <= 1'b1;
            misalign_q     <= |redirect_pc[1:0];
            state_q        <= S_REQ;
         end else begin
            case (state_q)
               S_BOOT: begin
                  imem_req_q <= 1'b1;
                  state_q    <= S_REQ;
               end
               S_REQ: begin
                  if (imem_ack) begin
                     format_q       <= imem_rdata;
                     pc_out_q       <= pc_q;
                     format_valid_q <= 1'b1;
                     imem_req_q     <= 1'b0;
                     state_q        <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (dec_ready) begin
                     pc_q           <= pc_next_d;
                     format_valid_q <= 1'b0;
                     instr_count_q  <= instr_count_q + XLEN'(1);
                     imem_req_q     <= 1'b1;
                     state_q        <= S_REQ;
                  end
               end
               default: begin
                  format_valid_q <= 1'b0;
                  imem_req_q     <= 1'b0;
                  state_q        <= S_BOOT;
               end
            endcase
         end
      end
   end

   assign imem_req     = imem_req_q;
   assign imem_addr    = pc_q;
   assign format       = format_q;
   assign format_valid = format_valid_q;
   assign pc_out       = pc_out_q;
   assign misalign     = misalign_q;
   assign instr_count  = instr_count_q;

endmodule

// File: doc/insr_fetch.md
INSR_FETCH -- requirements
Module: insr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter PC_STEP, default 32'd4, is the sequential PC increment.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  read address; equals pc while imem_req=1.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 format  output  32  instruction word presented to the decoder.
REQ-010 format_valid  output  1  format holds a valid instruction.
REQ-011 dec_ready  input  1  decoder consumes format this cycle.
REQ-012 redirect_valid  input  1  branch/jump/jalr redirect request.
REQ-013 redirect_pc  input  32  redirect target.
REQ-014 pc_out  output  32  PC of the word in format.
REQ-015 misalign  output  1  one-cycle pulse when redirect_pc[1:0]!=0.
REQ-016 instr_count  output  32  count of instructions handed to the decoder.

Function
REQ-017 The FSM SHALL have three states: S_BOOT, S_REQ, S_HOLD.
REQ-018 S_BOOT: imem_req=0, format_valid=0; next state S_REQ unconditionally.
REQ-019 S_REQ: imem_req=1, imem_addr=pc; imem_ack=1 -> format<=imem_rdata, pc_out<=pc, format_valid<=1, go to S_HOLD; otherwise stay in S_REQ with address stable.
REQ-020 S_HOLD: imem_req=0, format and pc_out stable; dec_ready=1 -> pc<=pc+PC_STEP, format_valid<=0, instr_count+=1, go to S_REQ.
REQ-021 Handover latency: fetch of the next word starts (imem_req=1) in the cycle after dec_ready was sampled high.
REQ-022 redirect_valid=1 in any state SHALL set pc<={redirect_pc[31:2],2'b00}, set format_valid<=0, and go to S_REQ next cycle.
REQ-023 Redirect has priority over imem_ack and dec_ready in the same cycle: the acked word is discarded and instr_count does not increment.
REQ-024 misalign SHALL be 1 in the cycle after a redirect whose redirect_pc[1:0]!=0, and 0 otherwise.
REQ-025 pc and instr_count SHALL wrap modulo 2^32 with no flag.
REQ-026 imem_ack outside S_REQ SHALL be ignored.
REQ-027 format SHALL change only on an accepted imem_ack in S_REQ.
REQ-028 format_valid SHALL never be 1 in S_REQ or S_BOOT.

Reset
REQ-029 rst_n=0 at posedge clk SHALL force: state=S_BOOT, pc=RESET_PC, format=32'h0000_0013 (NOP), pc_out=RESET_PC, format_valid=0, imem_req=0, misalign=0, instr_count=0.
REQ-030 Reset SHALL override all other inputs, including mid-fetch (S_REQ) and mid-hold (S_HOLD); an outstanding ack after reset SHALL be ignored.

Verification
REQ-031 Reset release, imem_ack one cycle after imem_req, dec_ready always 1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_count=3 after the third handover.
REQ-032 Word 0x00500093 acked at 0x0 with dec_ready=0 for 5 cycles -> format=0x00500093, format_valid=1 and imem_req=0 held all 5 cycles; then pc=0x4.
REQ-033 redirect_valid=1, redirect_pc=0x100 in the same cycle as imem_ack -> word discarded, format_valid=0 next cycle, next imem_addr=0x100, instr_count unchanged.
REQ-034 redirect_pc=0x206 -> next imem_addr=0x204, misalign=1 for exactly one cycle.
REQ-035 rst_n=0 while in S_REQ at pc=0x40 -> next cycle pc=RESET_PC, format_valid=0, imem_req=0; first post-reset fetch address=RESET_PC.
REQ-036 pc=0xFFFF_FFFC handed over -> next imem_addr=0x0000_0000.
